rx_response_ctrl: RTL

Host-side receive sequencer that owns the USB line decoder after the host finishes transmitting. It manages bus turnaround and enables the decoder. It then times out the wait for a device response and classifies the decoder's ACK/NAK/DATA0/load_data pulses against what the protocol layer expected. It reports one result per attempt and tracks consecutive failures so the protocol FSM knows when to retry and when to give up.

---
 rtl/rx_response_ctrl_if.sv | 30 +++
 rtl/rx_response_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_response_ctrl_if.sv
// Bundles the controller's protocol-layer handshake, decoder pulses and status outputs.
interface rx_response_ctrl_if;
  logic       start_rx;
  logic       expect_data;
  logic       abort;
  logic       clr_retry;
  logic       ACK_rec;
  logic       NAK_rec;
  logic       DATA0_rec;
  logic       load_data;
  logic       crc_ok;
  logic       rx_enable;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic [3:0] retry_cnt;
  logic       give_up;

  modport master (
    output start_rx, expect_data, abort, clr_retry,
    output ACK_rec, NAK_rec, DATA0_rec, load_data, crc_ok,
    input  rx_enable, busy, done, result, retry_cnt, give_up
  );

  modport slave (
    input  start_rx, expect_data, abort, clr_retry,
    input  ACK_rec, NAK_rec, DATA0_rec, load_data, crc_ok,
    output rx_enable, busy, done, result, retry_cnt, give_up
  );
endinterface

// File: rtl/rx_response_ctrl.sv
// Host receive sequencer: bus turnaround, response timeouts, PID/data classification
// and consecutive-failure tracking with a give-up pulse.
module rx_response_ctrl #(
  parameter int TURNAROUND     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_TIMEOUT   = 1024,
  parameter int MAX_RETRY      = 8
) (
  input logic               clock,
  input logic               reset_n,
  rx_response_ctrl_if.slave bus
);
  localparam int MAX_TMO = (TIMEOUT_CYCLES > DATA_TIMEOUT) ? TIMEOUT_CYCLES : DATA_TIMEOUT;
  localparam int MAX_CNT = (MAX_TMO > TURNAROUND) ? MAX_TMO : TURNAROUND;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] TURN_LAST = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] PID_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

  localparam logic [2:0] RES_NONE    = 3'd0;
  localparam logic [2:0] RES_ACK     = 3'd1;
  localparam logic [2:0] RES_NAK     = 3'd2;
  localparam logic [2:0] RES_DATA_OK = 3'd3;
  localparam logic [2:0] RES_CRC_ERR = 3'd4;
  localparam logic [2:0] RES_TIMEOUT = 3'd5;
  localparam logic [2:0] RES_UNEXP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_WAIT_PID,
    S_WAIT_DATA,
    S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exp_q, exp_d;
  logic          rx_enable_q, rx_enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          give_up_q, give_up_d;
  logic [2:0]    result_q, result_d;
  logic [3:0]    retry_cnt_q, retry_cnt_d;

  logic          report;
  logic [2:0]    res;
  logic          multi_pid;
  logic          success;
  logic [3:0]    retry_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      exp_q       <= 1'b0;
      rx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      give_up_q   <= 1'b0;
      result_q    <= RES_NONE;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      rx_enable_q <= rx_enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      give_up_q   <= give_up_d;
      result_q    <= result_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    result_d    = result_q;
    retry_cnt_d = retry_cnt_q;
    give_up_d   = 1'b0;
    report      = 1'b0;
    res         = RES_NONE;
    multi_pid   = (bus.ACK_rec & bus.NAK_rec) | (bus.ACK_rec & bus.DATA0_rec) |
                  (bus.NAK_rec & bus.DATA0_rec);
    retry_inc   = retry_cnt_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.start_rx && !bus.abort) begin
          state_d = S_TURN;
          cnt_d   = '0;
          exp_d   = bus.expect_data;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = S_WAIT_PID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_PID: begin
        cnt_d = cnt_q + CW'(1);
        // PID pulses are checked before the timer so a pulse on the last cycle wins.
        if (multi_pid) begin
          report = 1'b1;
          res    = RES_UNEXP;
        end else if (bus.ACK_rec) begin
          report = 1'b1;
          res    = exp_q ? RES_UNEXP : RES_ACK;
        end else if (bus.NAK_rec) begin
          report = 1'b1;
          res    = exp_q ? RES_UNEXP : RES_NAK;
        end else if (bus.DATA0_rec) begin
          if (exp_q) begin
            state_d = S_WAIT_DATA;
            cnt_d   = '0;
          end else begin
            report = 1'b1;
            res    = RES_UNEXP;
          end
        end else if (cnt_q == PID_LAST) begin
          report = 1'b1;
          res    = RES_TIMEOUT;
        end
      end
      S_WAIT_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.load_data) begin
          report = 1'b1;
          res    = bus.crc_ok ? RES_DATA_OK : RES_CRC_ERR;
        end else if (cnt_q == DATA_LAST) begin
          report = 1'b1;
          res    = RES_TIMEOUT;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      report  = 1'b0;
    end

    // A give-up leaves retry_cnt at the limit for the done cycle, then wraps.
    if (state_q == S_REPORT && give_up_q) begin
      retry_cnt_d = '0;
    end

    success = (res == RES_ACK) || (res == RES_DATA_OK);
    if (report) begin
      state_d  = S_REPORT;
      cnt_d    = '0;
      result_d = res;
      if (success) begin
        retry_cnt_d = '0;
      end else begin
        retry_cnt_d = retry_inc;
        give_up_d   = (retry_inc == RETRY_LIM);
      end
    end

    if (bus.clr_retry) begin
      retry_cnt_d = '0;
      give_up_d   = 1'b0;
    end

    done_d      = report;
    busy_d      = (state_d != S_IDLE);
    rx_enable_d = (state_d == S_WAIT_PID) || (state_d == S_WAIT_DATA);
  end

  assign bus.rx_enable = rx_enable_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.give_up   = give_up_q;
  assign bus.result    = result_q;
  assign bus.retry_cnt = retry_cnt_q;
endmodule
